mem_access_unit: RTL and testbench

Pipeline-side initiator for the byte-selectable word RAM. It accepts one load or store per handshake from the MEM stage and drives ram_rw, ram_sel, ram_addr and ram_data_in. It captures ram_data_out, then aligns and sign- or zero-extends it for the pipeline. It also detects misaligned and illegal accesses. The RAM acts on negedge clk; this unit is posedge-only, so each RAM access completes inside one ACCESS cycle.

---
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundles the pipeline request/response handshake and the word-RAM port of mem_access_unit.
// slave = the access unit's view; master = pipeline plus RAM side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              ram_rw;
  logic [3:0]        ram_sel;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, ram_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_rw, ram_sel, ram_addr, ram_data_in
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, ram_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_rw, ram_sel, ram_addr, ram_data_in
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-selectable word RAM: IDLE -> ACCESS -> RESP, all outputs registered.
// Optional macro MEM_ACCESS_RANGE_CHECK_EN flags addresses beyond the RAM as errors instead of wrapping.
module mem_access_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_ACCESS = 2'b01, ST_RESP = 2'b10} state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              ram_rw_q, ram_rw_d;
  logic [3:0]        ram_sel_q, ram_sel_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              misalign_s, range_err_s, req_err_s;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] sel;
    case (size)
      2'b00:   sel = 4'b0001 << ofs;
      2'b01:   sel = ofs[1] ? 4'b1100 : 4'b0011;
      2'b10:   sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = uns ? {24'h000000, d[7:0]} : {{24{d[7]}}, d[7:0]};
      2'b01:   r = uns ? {16'h0000, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Alignment and size legality of the offered request.
  always_comb begin
    misalign_s = 1'b0;
    case (bus.req_size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = bus.req_addr[0];
      2'b10:   misalign_s = |bus.req_addr[1:0];
      default: misalign_s = 1'b1;
    endcase
  end

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  assign range_err_s = |bus.req_addr[31:ADDR_W+2];
`else
  assign range_err_s = 1'b0;
`endif
  assign req_err_s = misalign_s | range_err_s;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    ram_rw_d     = ram_rw_q;
    ram_sel_d    = ram_sel_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d   = bus.req_we;
          size_d = bus.req_size;
          uns_d  = bus.req_unsigned;
          if (req_err_s) begin
            // Faulty requests bypass the RAM entirely.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            ram_rw_d     = 1'b0;
            ram_sel_d    = 4'b0000;
          end else begin
            state_d    = ST_ACCESS;
            ram_rw_d   = bus.req_we;
            ram_sel_d  = lane_sel(bus.req_size, bus.req_addr[1:0]);
            ram_addr_d = bus.req_addr[ADDR_W+1:2];
            ram_din_d  = store_data(bus.req_size, bus.req_wdata);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // RAM completed on the mid-cycle negedge; its output is valid now.
        state_d      = ST_RESP;
        ram_rw_d     = 1'b0;
        ram_sel_d    = 4'b0000;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = we_q ? '0 : load_ext(size_q, uns_q, bus.ram_data_out);
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        ram_rw_d     = 1'b0;
        ram_sel_d    = 4'b0000;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      ram_rw_q     <= 1'b0;
      ram_sel_q    <= 4'b0000;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      ram_rw_q     <= ram_rw_d;
      ram_sel_q    <= ram_sel_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.ram_rw      = ram_rw_q;
  assign bus.ram_sel     = ram_sel_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_data_in = ram_din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a negedge byte-lane RAM model.
// Range expectations follow MEM_ACCESS_RANGE_CHECK_EN.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();
  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [0:1023];
  int writes = 0;
  int checks = 0;
  int failures = 0;

  function automatic int lane_shift(input logic [3:0] sel);
    if (sel[0]) return 0;
    if (sel[1]) return 8;
    if (sel[2]) return 16;
    if (sel[3]) return 24;
    return 0;
  endfunction

  // RAM model acting on negedge, read data shifted down to the lowest selected lane.
  always @(negedge clk) begin
    if (bus.ram_rw) begin
      for (int l = 0; l < 4; l++)
        if (bus.ram_sel[l]) mem[bus.ram_addr][8*l +: 8] = bus.ram_data_in[8*l +: 8];
      writes++;
    end
    bus.ram_data_out <= mem[bus.ram_addr] >> lane_shift(bus.ram_sel);
  end

  logic        a_rw;
  logic [3:0]  a_sel;
  logic [9:0]  a_addr;
  logic [31:0] a_din;
  logic [31:0] rd;
  logic        e;
  int          lat;
  int          w0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    a_rw = bus.ram_rw; a_sel = bus.ram_sel; a_addr = bus.ram_addr; a_din = bus.ram_data_in;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.resp_rdata; e = bus.resp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_ram_rw", {31'd0, bus.ram_rw}, 32'd0);
    chk("rst_ram_sel", {28'd0, bus.ram_sel}, 32'd0);
    chk("rst_ram_addr", {22'd0, bus.ram_addr}, 32'd0);
    chk("rst_ram_din", bus.ram_data_in, 32'h0);
    rst_n = 1'b1;

    // Word store then load.
    w0 = writes;
    run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_rw", {31'd0, a_rw}, 32'd1);
    chk("sw_sel", {28'd0, a_sel}, 32'hF);
    chk("sw_addr", {22'd0, a_addr}, 32'd4);
    chk("sw_din", a_din, 32'hDEADBEEF);
    chk("sw_lat", lat, 32'd2);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", {31'd0, e}, 32'd0);
    chk("sw_writes", writes - w0, 32'd1);
    w0 = writes;
    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_rw", {31'd0, a_rw}, 32'd0);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'd0, e}, 32'd0);
    chk("lw_writes", writes - w0, 32'd0);

    // Byte loads.
    run(1'b1, 2'b10, 1'b0, 32'h10, 32'h80F17F01);
    run(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    chk("lb12_sel", {28'd0, a_sel}, 32'h4);
    chk("lb12", rd, 32'hFFFFFFF1);
    run(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    chk("lbu12", rd, 32'h000000F1);
    run(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("lb11", rd, 32'h0000007F);
    run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lb13", rd, 32'hFFFFFF80);
    run(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    chk("lw_uns_ignored", rd, 32'h80F17F01);

    // Half and byte stores into word 5.
    run(1'b1, 2'b10, 1'b0, 32'h14, 32'h0);
    run(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000A55A);
    chk("sh_sel", {28'd0, a_sel}, 32'hC);
    chk("sh_din", a_din, 32'hA55AA55A);
    chk("sh_addr", {22'd0, a_addr}, 32'd5);
    run(1'b0, 2'b01, 1'b0, 32'h16, 32'h0);
    chk("lh16", rd, 32'hFFFFA55A);
    run(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
    chk("lhu16", rd, 32'h0000A55A);
    run(1'b1, 2'b00, 1'b0, 32'h15, 32'h000000AB);
    chk("sb_sel", {28'd0, a_sel}, 32'h2);
    chk("sb_din", a_din, 32'hABABABAB);
    run(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    chk("lw14_merge", rd, 32'hA55AAB00);

    // Misaligned and illegal accesses.
    w0 = writes;
    run(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
    chk("lw11_err", {31'd0, e}, 32'd1);
    chk("lw11_rdata", rd, 32'h0);
    chk("lw11_lat", lat, 32'd1);
    chk("lw11_sel", {28'd0, a_sel}, 32'd0);
    run(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF);
    chk("sh13_err", {31'd0, e}, 32'd1);
    chk("sh13_rw", {31'd0, a_rw}, 32'd0);
    chk("sh13_lat", lat, 32'd1);
    run(1'b1, 2'b11, 1'b0, 32'h10, 32'h1234);
    chk("sz11_err", {31'd0, e}, 32'd1);
    chk("sz11_rdata", rd, 32'h0);
    chk("err_writes", writes - w0, 32'd0);

    // Backpressure: response held, new request ignored.
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("bp_rdata", bus.resp_rdata, 32'h80F17F01);
    w0 = writes;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("bp_hold_rdata", bus.resp_rdata, 32'h80F17F01);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    chk("bp_no_write", writes - w0, 32'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("bp_rel_ready", {31'd0, bus.req_ready}, 32'd1);

    // Reset during the ACCESS cycle of a store.
    run(1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h22222222;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstmid_access_rw", {31'd0, bus.ram_rw}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_rw", {31'd0, bus.ram_rw}, 32'd0);
    chk("rstmid_sel", {28'd0, bus.ram_sel}, 32'd0);
    chk("rstmid_addr", {22'd0, bus.ram_addr}, 32'd0);
    chk("rstmid_din", bus.ram_data_in, 32'h0);
    chk("rstmid_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstmid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    run(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("rstmid_after_lw", rd, 32'h11111111);
    chk("rstmid_after_lat", lat, 32'd2);

    // Out-of-range address.
    run(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D);
    run(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    chk("range_err", {31'd0, e}, 32'd1);
    chk("range_rdata", rd, 32'h0);
    chk("range_sel", {28'd0, a_sel}, 32'd0);
`else
    chk("range_addr", {22'd0, a_addr}, 32'd0);
    chk("range_err", {31'd0, e}, 32'd0);
    chk("range_rdata", rd, 32'hCAFEF00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
